mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the instruction-fetch requester (I, read-only) and the data requester (D, read/write) of the MIPS core.
- Sequences each access with a request/ready handshake.
- Returns read data and a one-cycle DONE pulse to the owning requester.
- Drives STALL so PC and the pipeline hold while an access is outstanding.
- Sits between PC/Instruction_memory/Data_memory users and the backing memory model.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_wait_cnt.sv | 39 +++
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified memory port arbiter
//
// Holds the FSM state encoding, the owner encoding and the read data
// returned to a requester whose access was aborted by the wait timeout.

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// rtl/mem_arb_wait_cnt.sv - BUSY-cycle wait counter with terminal count
//
// Counts the BUSY cycles of the current access.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   i_clr   : clear, asserted on the IDLE->BUSY transition
//   i_en    : count enable, asserted while BUSY
//   o_tc    : high during the TIMEOUT-th BUSY cycle of the access

module mem_arb_wait_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    // The register holds the number of BUSY cycles already completed, so it
    // never needs to represent more than TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_tc = w_tc;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            // Saturate at the terminal value; the arbiter leaves BUSY there.
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
//
// Optional feature macro: MEM_ARB_RR_EN (round-robin between I and D when
// both request in IDLE; otherwise D has fixed priority over I).
//
// Ports:
//   i_clk, i_reset      : clock (rising edge), synchronous active-high reset
//   i_i_req, i_i_addr   : fetch request (level) and address
//   o_i_rdata, o_i_done : fetched word and one-cycle completion pulse
//   i_d_req, i_d_we     : data request (level) and write enable
//   i_d_addr, i_d_wdata : data address and write data
//   o_d_rdata, o_d_done : data read word and one-cycle completion pulse
//   o_mem_req/we/addr/wdata : registered request towards the memory
//   i_mem_rdata, i_mem_ready: memory read data and completion strobe
//   o_stall             : holds PC/pipeline while a request is unanswered
//   o_timeout_err       : sticky flag, set when an access timed out

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_i_req,
    input  logic [ADDR_W-1:0] i_i_addr,
    output logic [DATA_W-1:0] o_i_rdata,
    output logic              o_i_done,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_done,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_stall,
    output logic              o_timeout_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    arb_owner_t        w_grant_owner;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_timeout_err;

    logic              w_start;
    logic              w_finish_ok;
    logic              w_finish_to;
    logic              w_tc;
    logic              w_i_done;
    logic              w_d_done;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    arb_owner_t r_last_grant;

    // On contention the requester that was not served last wins.
    always_comb begin
        w_grant_owner = OWN_I;
        if (i_i_req && i_d_req) begin
            w_grant_owner = (r_last_grant == OWN_D) ? OWN_I : OWN_D;
        end else if (i_d_req) begin
            w_grant_owner = OWN_D;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= OWN_D;
        end else if (w_start) begin
            r_last_grant <= w_grant_owner;
        end
    end
`else
    assign w_grant_owner = i_d_req ? OWN_D : OWN_I;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish_ok = 1'b0;
        w_finish_to = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_i_req || i_d_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A response in the terminal-count cycle still counts as a
                // normal completion.
                if (i_mem_ready) begin
                    w_finish_ok = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_tc) begin
                    w_finish_to = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    mem_arb_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_start),
        .i_en    (r_state == BUSY),
        .o_tc    (w_tc)
    );

    // ------------------------------------------------------------------
    // Memory-side request registers and returned data
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner       <= OWN_I;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_owner   <= w_grant_owner;
                r_mem_req <= 1'b1;
                if (w_grant_owner == OWN_D) begin
                    r_mem_we    <= i_d_we;
                    r_mem_addr  <= i_d_addr;
                    r_mem_wdata <= i_d_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= i_i_addr;
                    r_mem_wdata <= '0;
                end
            end

            if (w_finish_ok || w_finish_to) begin
                r_mem_req <= 1'b0;
            end

            // Writes return nothing, so D_RDATA keeps its previous value.
            if (w_finish_ok && !r_mem_we) begin
                if (r_owner == OWN_D) begin
                    r_d_rdata <= i_mem_rdata;
                end else begin
                    r_i_rdata <= i_mem_rdata;
                end
            end

            if (w_finish_to) begin
                r_timeout_err <= 1'b1;
                if (r_owner == OWN_D) begin
                    r_d_rdata <= DATA_W'(TIMEOUT_RDATA);
                end else begin
                    r_i_rdata <= DATA_W'(TIMEOUT_RDATA);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_i_done = (r_state == RESP) && (r_owner == OWN_I);
    assign w_d_done = (r_state == RESP) && (r_owner == OWN_D);

    assign o_i_done      = w_i_done;
    assign o_d_done      = w_d_done;
    assign o_i_rdata     = r_i_rdata;
    assign o_d_rdata     = r_d_rdata;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_timeout_err = r_timeout_err;

    // A requester stops stalling in the very cycle its DONE is presented.
    assign o_stall = (i_i_req & ~w_i_done) | (i_d_req & ~w_d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_done, d_done;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_i_req       (i_req),
        .i_i_addr      (i_addr),
        .o_i_rdata     (i_rdata),
        .o_i_done      (i_done),
        .i_d_req       (d_req),
        .i_d_we        (d_we),
        .i_d_addr      (d_addr),
        .i_d_wdata     (d_wdata),
        .o_d_rdata     (d_rdata),
        .o_d_done      (d_done),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .i_mem_ready   (mem_ready),
        .o_stall       (stall),
        .o_timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int i_done_cyc = -1;
    int d_done_cyc = -1;
    int mreq_cnt   = 0;
    bit cmp_en     = 1'b0;

    // Requester state (what each requester is currently asking for)
    bit          ip, dp, dp_we;
    logic [31:0] ip_addr, dp_addr, dp_wdata;
    // Architectural model state
    logic [31:0] m_i_rdata, m_d_rdata;
    bit          m_err;
    bit          m_last;  // 1 = D was granted last
    // Expected outputs for the current cycle
    logic        exp_i_done, exp_d_done, exp_mem_req, exp_mem_we, exp_stall, exp_err;
    logic [31:0] exp_mem_addr, exp_mem_wdata, exp_i_rdata, exp_d_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("i_done", 32'(i_done), 32'(exp_i_done));
            chk("d_done", 32'(d_done), 32'(exp_d_done));
            chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("timeout_err", 32'(timeout_err), 32'(exp_err));
            chk("i_rdata", i_rdata, exp_i_rdata);
            chk("d_rdata", d_rdata, exp_d_rdata);
            if (exp_mem_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
                chk("mem_addr", mem_addr, exp_mem_addr);
                if (exp_mem_we) chk("mem_wdata", mem_wdata, exp_mem_wdata);
            end
        end
        if (i_done) i_done_cyc = cyc;
        if (d_done) d_done_cyc = cyc;
        if (mem_req) mreq_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive requester inputs and derive the model-dependent expectations.
    task automatic drive_cycle();
        i_req       = ip;
        i_addr      = ip_addr;
        d_req       = dp;
        d_we        = dp_we;
        d_addr      = dp_addr;
        d_wdata     = dp_wdata;
        exp_i_rdata = m_i_rdata;
        exp_d_rdata = m_d_rdata;
        exp_err     = m_err;
        exp_stall   = (ip & ~exp_i_done) | (dp & ~exp_d_done);
    endtask

    task automatic raise_i(input logic [31:0] a);
        ip      = 1'b1;
        ip_addr = a;
    endtask

    task automatic raise_d(input bit we, input logic [31:0] a, input logic [31:0] w);
        dp       = 1'b1;
        dp_we    = we;
        dp_addr  = a;
        dp_wdata = w;
    endtask

    task automatic idle_cycle(input bit rdy);
        exp_i_done  = 1'b0;
        exp_d_done  = 1'b0;
        exp_mem_req = 1'b0;
        exp_mem_we  = 1'b0;
        mem_ready   = rdy;
        mem_rdata   = $urandom();
        drive_cycle();
        tick();
    endtask

    // One access seen from the grant cycle (t=0) to its DONE cycle (t=L+1).
    // lat_in: BUSY cycle in which memory answers; > TO means never.
    task automatic do_access(input int lat_in, input logic [31:0] mrd,
                             input int rst_at, input bit rnd);
        bit          own;
        bit          a_we;
        logic [31:0] a_addr, a_wdata;
        int          lat, len;
        if (ip && dp) own = RR ? ~m_last : 1'b1;
        else          own = dp;
        m_last  = own;
        a_we    = own & dp_we;
        a_addr  = own ? dp_addr : ip_addr;
        a_wdata = dp_wdata;
        lat     = (lat_in > 0) ? lat_in : int'($urandom_range(1, TO + 2));
        len     = (lat <= TO) ? lat : TO;
        for (int t = 0; t <= len + 1; t++) begin
            if (rnd && t == 1 && $urandom_range(0, 7) == 0) begin
                if (own) begin dp = 1'b0; dp_addr = $urandom(); end
                else     begin ip = 1'b0; ip_addr = $urandom(); end
            end
            if (rnd && t >= 1) begin
                if (own && !ip && $urandom_range(0, 3) == 0) raise_i($urandom());
                if (!own && !dp && $urandom_range(0, 3) == 0)
                    raise_d(1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
            exp_mem_req   = (t >= 1 && t <= len);
            exp_mem_we    = a_we;
            exp_mem_addr  = a_addr;
            exp_mem_wdata = a_wdata;
            if (t >= 1 && t <= len) mem_ready = (t == lat);
            else                    mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = (t == lat) ? mrd : $urandom();
            exp_i_done = (t == len + 1) && !own;
            exp_d_done = (t == len + 1) && own;
            if (t == len + 1) begin
                if (lat <= TO) begin
                    if (!a_we) begin
                        if (own) m_d_rdata = mrd;
                        else     m_i_rdata = mrd;
                    end
                end else begin
                    if (own) m_d_rdata = BAD;
                    else     m_i_rdata = BAD;
                    m_err = 1'b1;
                end
            end
            reset = (t == rst_at);
            drive_cycle();
            tick();
            if (t == rst_at) begin
                reset     = 1'b0;
                m_i_rdata = '0;
                m_d_rdata = '0;
                m_err     = 1'b0;
                m_last    = 1'b1;
                return;
            end
        end
        if (own) dp = 1'b0;
        else     ip = 1'b0;
    endtask

    initial begin
        int s, m0;
        reset = 1'b1;
        ip = 0; dp = 0; dp_we = 0;
        ip_addr = '0; dp_addr = '0; dp_wdata = '0;
        m_i_rdata = '0; m_d_rdata = '0; m_err = 0; m_last = 1'b1;
        mem_ready = 1'b0; mem_rdata = '0;
        exp_i_done = 0; exp_d_done = 0; exp_mem_req = 0; exp_mem_we = 0;
        exp_mem_addr = '0; exp_mem_wdata = '0;
        drive_cycle();
        tick();
        tick();
        cmp_en = 1'b1;
        tick();                 // reset-state compare while reset is held
        reset = 1'b0;
        idle_cycle(1'b0);

        // Fetch read, zero-wait memory
        raise_i(32'h0000_0040);
        s = cyc;
        do_access(1, 32'h2008_0005, -1, 1'b0);
        chk("fetch_done_latency", 32'(i_done_cyc - s), 32'd2);
        chk("fetch_rdata", i_rdata, 32'h2008_0005);

        // Data write answered in the 3rd BUSY cycle
        raise_d(1'b1, 32'h0000_0100, 32'hCAFE_0001);
        s  = cyc;
        m0 = mreq_cnt;
        do_access(3, 32'h5555_AAAA, -1, 1'b0);
        chk("write_busy_cycles", 32'(mreq_cnt - m0), 32'd3);
        chk("write_done_latency", 32'(d_done_cyc - s), 32'd4);
        chk("write_d_rdata_kept", d_rdata, 32'h0);

        // Contention, last grant was D
        raise_i(32'h0000_0200);
        raise_d(1'b0, 32'h0000_0300, 32'h0);
        s = cyc;
        do_access(1, 32'h1111_1111, -1, 1'b0);
        do_access(1, 32'h2222_2222, -1, 1'b0);
`ifdef MEM_ARB_RR_EN
        chk("contention_i_latency", 32'(i_done_cyc - s), 32'd2);
        chk("contention_d_latency", 32'(d_done_cyc - s), 32'd5);
`else
        chk("contention_d_latency", 32'(d_done_cyc - s), 32'd2);
        chk("contention_i_latency", 32'(i_done_cyc - s), 32'd5);
`endif

        // Timeout on a D read, then a late MEM_READY
        raise_d(1'b0, 32'h0000_0400, 32'h0);
        s = cyc;
        do_access(TO + 5, 32'h0, -1, 1'b0);
        chk("timeout_done_latency", 32'(d_done_cyc - s), 32'd5);
        chk("timeout_rdata", d_rdata, 32'hDEAD_BEEF);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        chk("late_ready_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // MEM_READY with nothing outstanding
        repeat (3) idle_cycle(1'b1);

        // Reset in the second BUSY cycle, request held and re-served
        raise_i(32'h0000_0500);
        do_access(TO + 5, 32'h0, 2, 1'b0);
        chk("reset_clears_err", 32'(timeout_err), 32'd0);
        chk("reset_drops_mem_req", 32'(mem_req), 32'd0);
        s = cyc;
        do_access(2, 32'hABCD_0123, -1, 1'b0);
        chk("reissue_latency", 32'(i_done_cyc - s), 32'd3);
        chk("reissue_rdata", i_rdata, 32'hABCD_0123);

        // Randomized traffic
        repeat (300) begin
            if (!ip && $urandom_range(0, 1) == 1) raise_i($urandom());
            if (!dp && $urandom_range(0, 1) == 1)
                raise_d(1'($urandom_range(0, 1)), $urandom(), $urandom());
            if (ip || dp) do_access(0, $urandom(), -1, 1'b1);
            else          idle_cycle(1'($urandom_range(0, 1)));
        end
        while (ip || dp) do_access(0, $urandom(), -1, 1'b1);
        idle_cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
